audio_tone_gen: RTL and testbench
=================================

# audio_tone_gen

Square-wave tone generator that sits directly downstream of the processor-to-audio interface. It consumes that interface's audioEn gate together with a processor-supplied pitch and volume, and drives the 1-bit PWM audio pin and the amplifier shutdown pin. Notes start on a fresh phase and always end on a completed period, so there are no clicks. Pitch and volume changes take effect only at half-period boundaries.

## Interface
Parameters:
- PITCH_W, 18: width of pitch input (half-period in clk25 cycles).
- VOL_W, 4: width of volume input; PWM carrier period is 2^VOL_W cycles.
- MIN_HALF, 16: minimum legal half-period; nonzero pitches below this are clamped up to it.

Ports:
- clk25  input  1  system clock, 25 MHz; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- audioEn  input  1  play gate from the upstream duration interface.
- pitch  input  PITCH_W  half-period in cycles; 0 = rest.
- volume  input  VOL_W  PWM duty numerator; 0 = silent.
- audioOut  output  1  registered PWM audio pin.
- audioSD  output  1  amplifier enable; high whenever state ≠ IDLE.
- busy  output  1  high in PLAY or DRAIN.

## Operation
Registers:
- state: IDLE, PLAY or DRAIN.
- wave: square-wave level.
- half_cnt: PITCH_W-bit down-counter.
- pwm_cnt: VOL_W-bit free-running up-counter while busy; wraps from 2^VOL_W−1 to 0.
- p_lat, v_lat: latched pitch and volume.
- audioOut register.

Effective pitch: p_eff = 0 if pitch = 0; MIN_HALF if 0 < pitch < MIN_HALF; otherwise pitch.

IDLE:
- On audioEn = 1: go to PLAY; wave ← 1; p_lat ← p_eff; v_lat ← volume; half_cnt ← p_eff − 1; pwm_cnt ← 0.

PLAY:
- half_cnt decrements each cycle.
- When half_cnt = 0:
  - wave toggles.
  - p_lat ← p_eff and v_lat ← volume, both sampled at that edge.
  - half_cnt ← p_eff − 1.
- audioEn = 0 sampled: go to DRAIN. The counters continue without interruption.

DRAIN:
- Counting continues exactly as in PLAY.
- audioEn = 1: return to PLAY with no phase reset.
- At the half_cnt = 0 edge where wave = 0 (the low→high transition point): go to IDLE; wave ← 0.

Rest handling (p_lat = 0):
- wave is held at 0 and half_cnt at 0.
- Each cycle, p_eff is re-sampled. A nonzero p_eff restarts the wave exactly as on IDLE exit, but without a state change.
- DRAIN with rest: go to IDLE on the next edge.

Output rule:
- audioOut ← wave_next ∧ busy_next ∧ (pwm_cnt_next < v_lat_next), computed from next-state values.
- A full half-period of wave = 1 therefore gives exactly v_lat high cycles per 16-cycle carrier window.

Priority and simultaneous events:
- Reset dominates everything.
- In IDLE, only audioEn is examined.
- A half-period boundary and an audioEn fall on the same edge: both take effect (toggle, reload and DRAIN entry).

## Timing
- Reset (asynchronous, reset = 0): state = IDLE; wave, audioOut, audioSD, busy = 0; all counters and latches = 0. Outputs go low without waiting for a clock edge. Deassertion is taken at a clk25 edge.
- audioEn is sampled at the rising edge. IDLE→PLAY latency is 1 edge: busy, audioSD and audioOut (if volume > 0) are all high after the first edge that samples audioEn = 1.
- With pitch P ≥ MIN_HALF constant: wave is high for exactly P cycles, then low for P cycles; period = 2P cycles.
- A pitch or volume change mid-half-period does not affect the current half.
- DRAIN exit: audioSD, busy and audioOut all fall on the same edge. The last audible period is always complete.
- Maximum tail after audioEn falls: 2·p_lat cycles.

## Test plan
- Reset: hold reset = 0 with audioEn = 1 and pitch = 100 -> audioOut = audioSD = busy = 0 throughout. After reset = 1, busy rises at the first edge.
- pitch = 20, volume = 15, audioEn rises -> busy at edge 1; audioOut high for 15 of every 16 cycles during the 20-cycle high half and 0 for the 20-cycle low half; period = 40.
- audioEn falls at cycle 5 of a high half (pitch = 20) -> DRAIN; 15 more high cycles and 20 low cycles, then audioSD = busy = audioOut = 0 on the same edge. Re-asserting audioEn during the low half -> return to PLAY, no phase jump.
- Pitch changes from 20 to 30 at cycle 7 of a half -> that half stays 20 cycles; subsequent halves are 30 cycles. Volume changes from 15 to 4 mid-half -> the new duty applies only from the next half.
- pitch = 5 -> half-period of 16 cycles. pitch = 0 in PLAY -> audioOut = 0, audioSD = 1; a later pitch = 20 restarts with a full 20-cycle high half.
- Reset dropped mid-PLAY (audioOut = 1) -> all outputs are 0 before the next clk25 edge and the state is IDLE.

Source files
------------

// File: rtl/audio_tone_gen.sv
`timescale 1ns/1ps
// audio_tone_gen
// Square-wave tone generator placed after the processor-to-audio interface.
// It turns a play gate, a half-period pitch and a PWM volume into a 1-bit
// PWM audio pin and an amplifier enable. A note always starts on a fresh
// phase and always ends after a complete period. Pitch and volume are only
// taken up at half-period boundaries, which keeps the output free of clicks.
//
// Ports
//   clk25     in   system clock (25 MHz), rising-edge active
//   reset     in   asynchronous reset, active low
//   audioEn   in   play gate from the upstream duration logic
//   pitch     in   half-period in clk25 cycles, 0 = rest
//   volume    in   PWM duty numerator, 0 = silent
//   audioOut  out  registered PWM audio pin
//   audioSD   out  amplifier enable, high whenever a note is active
//   busy      out  high while playing or draining the last period
module audio_tone_gen #(
    parameter int PITCH_W  = 18,
    parameter int VOL_W    = 4,
    parameter int MIN_HALF = 16
) (
    input  logic               clk25,
    input  logic               reset,
    input  logic               audioEn,
    input  logic [PITCH_W-1:0] pitch,
    input  logic [VOL_W-1:0]   volume,
    output logic               audioOut,
    output logic               audioSD,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [PITCH_W-1:0] MinHalf = PITCH_W'(MIN_HALF);

    state_t             state_q, state_d;
    logic               wave_q, wave_d;
    logic [PITCH_W-1:0] halfCnt_q, halfCnt_d;
    logic [PITCH_W-1:0] pLat_q, pLat_d;
    logic [VOL_W-1:0]   pwmCnt_q, pwmCnt_d;
    logic [VOL_W-1:0]   vLat_q, vLat_d;
    logic               busy_q, busy_d;
    logic               audioOut_q, audioOut_d;
    logic [PITCH_W-1:0] pEff;
    logic               halfDone;
    logic               gateLow;

    // Nonzero pitches shorter than the minimum half-period are clamped up.
    always_comb begin
        if (pitch == '0) begin
            pEff = '0;
        end else if (pitch < MinHalf) begin
            pEff = MinHalf;
        end else begin
            pEff = pitch;
        end
    end

    assign halfDone = (halfCnt_q == '0);
    assign gateLow  = ~audioEn;

    always_comb begin
        state_d   = state_q;
        wave_d    = wave_q;
        halfCnt_d = halfCnt_q;
        pLat_d    = pLat_q;
        vLat_d    = vLat_q;
        pwmCnt_d  = pwmCnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                pwmCnt_d = '0;
                if (audioEn) begin
                    // A rest pitch at note start lands directly in the rest hold.
                    state_d   = PLAY;
                    wave_d    = (pEff != '0);
                    pLat_d    = pEff;
                    vLat_d    = volume;
                    halfCnt_d = (pEff != '0) ? pEff - 1'b1 : '0;
                end
            end

            default: begin
                // PLAY and DRAIN share the counting; only the gate decides
                // which of the two we are in after this edge.
                state_d = audioEn ? PLAY : DRAIN;

                if (pLat_q == '0) begin
                    // Rest: hold the wave low and watch for a usable pitch.
                    if (state_q == DRAIN && gateLow) begin
                        state_d   = IDLE;
                        wave_d    = 1'b0;
                        halfCnt_d = '0;
                        pwmCnt_d  = '0;
                    end else if (pEff != '0) begin
                        wave_d    = 1'b1;
                        pLat_d    = pEff;
                        vLat_d    = volume;
                        halfCnt_d = pEff - 1'b1;
                        pwmCnt_d  = '0;
                    end
                end else if (halfDone) begin
                    // The end of a low half is the only clean place to stop.
                    if (state_q == DRAIN && gateLow && !wave_q) begin
                        state_d   = IDLE;
                        wave_d    = 1'b0;
                        halfCnt_d = '0;
                        pwmCnt_d  = '0;
                    end else begin
                        wave_d    = (pEff != '0) && !wave_q;
                        pLat_d    = pEff;
                        vLat_d    = volume;
                        halfCnt_d = (pEff != '0) ? pEff - 1'b1 : '0;
                    end
                end else begin
                    halfCnt_d = halfCnt_q - 1'b1;
                end
            end
        endcase
    end

    // Outputs are computed from next-state values so they line up with the
    // state they describe on the same edge.
    always_comb begin
        busy_d     = (state_d != IDLE);
        audioOut_d = wave_d && busy_d && (pwmCnt_d < vLat_d);
    end

    always_ff @(posedge clk25 or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            wave_q     <= 1'b0;
            halfCnt_q  <= '0;
            pLat_q     <= '0;
            pwmCnt_q   <= '0;
            vLat_q     <= '0;
            busy_q     <= 1'b0;
            audioOut_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wave_q     <= wave_d;
            halfCnt_q  <= halfCnt_d;
            pLat_q     <= pLat_d;
            pwmCnt_q   <= pwmCnt_d;
            vLat_q     <= vLat_d;
            busy_q     <= busy_d;
            audioOut_q <= audioOut_d;
        end
    end

    assign audioOut = audioOut_q;
    assign audioSD  = busy_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_audio_tone_gen.sv
`timescale 1ns/1ps
// tb_audio_tone_gen
// Self-checking bench for audio_tone_gen: a table of aligned note segments,
// hand-written sequences for reset, drain, re-trigger and pitch change, and
// a randomized run compared against a phase-position reference model.
module tb_audio_tone_gen;

    localparam int PITCH_W  = 18;
    localparam int VOL_W    = 4;
    localparam int MIN_HALF = 16;
    localparam int CARRIER  = 16;

    logic               clk25 = 1'b0;
    logic               reset;
    logic               audioEn;
    logic [PITCH_W-1:0] pitch;
    logic [VOL_W-1:0]   volume;
    logic               audioOut;
    logic               audioSD;
    logic               busy;

    int nVectors     = 0;
    int nMiscompares = 0;

    typedef struct {
        logic en;
        int   pitch;
        int   vol;
        int   cycles;
        int   expHighs;
        logic expBusy;
    } vec_t;

    vec_t vecs[12];

    // Reference model: position within the current half-period and the
    // carrier phase, advanced once per clock edge.
    bit mBusy;
    bit mPlaying;
    bit mHigh;
    int mP;
    int mV;
    int mPos;
    int mTick;

    audio_tone_gen #(
        .PITCH_W (PITCH_W),
        .VOL_W   (VOL_W),
        .MIN_HALF(MIN_HALF)
    ) dut (
        .clk25   (clk25),
        .reset   (reset),
        .audioEn (audioEn),
        .pitch   (pitch),
        .volume  (volume),
        .audioOut(audioOut),
        .audioSD (audioSD),
        .busy    (busy)
    );

    always #20 clk25 = ~clk25;

    function automatic int effPitch(input int p);
        if (p == 0) return 0;
        if (p < MIN_HALF) return MIN_HALF;
        return p;
    endfunction

    task automatic modelReset();
        mBusy = 0; mPlaying = 0; mHigh = 0;
        mP = 0; mV = 0; mPos = 0; mTick = 0;
    endtask

    task automatic startNote(input int pe, input int v, input bit en);
        mBusy = 1; mPlaying = en; mHigh = (pe != 0);
        mP = pe; mV = v; mPos = 1; mTick = 0;
    endtask

    task automatic modelStep(input bit en, input int p, input int v);
        int pe;
        pe = effPitch(p);
        if (!mBusy) begin
            if (en) startNote(pe, v, 1'b1);
            return;
        end
        mTick = (mTick + 1) % CARRIER;
        if (mP == 0) begin
            if (!mPlaying && !en) begin
                mBusy = 0; mHigh = 0;
            end else begin
                mPlaying = en;
                if (pe != 0) startNote(pe, v, en);
            end
        end else if (mPos == mP) begin
            if (!mPlaying && !en && !mHigh) begin
                mBusy = 0; mHigh = 0;
            end else begin
                mPlaying = en;
                mHigh = (pe != 0) && !mHigh;
                mP = pe; mV = v; mPos = 1;
            end
        end else begin
            mPos++;
            mPlaying = en;
        end
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        nVectors++;
        if (actual != expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic en, input int p, input int v);
        @(negedge clk25);
        audioEn = en;
        pitch   = PITCH_W'(p);
        volume  = VOL_W'(v);
    endtask

    task automatic doReset();
        @(negedge clk25);
        reset = 1'b0; audioEn = 1'b0; pitch = '0; volume = '0;
        repeat (2) @(negedge clk25);
        reset = 1'b1;
        modelReset();
    endtask

    task automatic compareModel(input string tag);
        int expOut;
        expOut = (mBusy && mHigh && (mTick < mV)) ? 1 : 0;
        checkOutput({tag, "_out"}, int'(audioOut), expOut);
        checkOutput({tag, "_sd"}, int'(audioSD), int'(mBusy));
        checkOutput({tag, "_busy"}, int'(busy), int'(mBusy));
    endtask

    function automatic logic [PITCH_W-1:0] randPitch();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) return '0;
        if (sel == 1) return PITCH_W'($urandom_range(1, 15));
        return PITCH_W'($urandom_range(16, 40));
    endfunction

    initial begin
        int highs;
        int busyCount;
        int fallEdge;
        int outAtFall;
        int sdAtFall;
        int highCount;

        // Segments run back to back; expected counts assume the edge
        // numbering of one continuous note starting at the second segment.
        vecs[0]  = '{1'b0, 16, 15,  3,  0, 1'b0};
        vecs[1]  = '{1'b1, 16, 15, 32, 15, 1'b1};
        vecs[2]  = '{1'b1, 16,  4,  8,  4, 1'b1};
        vecs[3]  = '{1'b1, 16, 15,  8,  0, 1'b1};
        vecs[4]  = '{1'b1, 16, 15, 16,  0, 1'b1};
        vecs[5]  = '{1'b0, 16, 15, 16, 15, 1'b1};
        vecs[6]  = '{1'b0, 16, 15, 16,  0, 1'b1};
        vecs[7]  = '{1'b0, 16, 15,  2,  0, 1'b0};
        vecs[8]  = '{1'b1,  5, 15, 32, 15, 1'b1};
        vecs[9]  = '{1'b1,  0, 15, 32,  0, 1'b1};
        vecs[10] = '{1'b1, 20, 15, 20, 19, 1'b1};
        vecs[11] = '{1'b1, 20,  0, 40,  0, 1'b1};

        // Reset held with the gate asserted keeps everything quiet.
        reset = 1'b0; audioEn = 1'b1; pitch = PITCH_W'(100); volume = VOL_W'(15);
        modelReset();
        for (int c = 0; c < 5; c++) begin
            @(posedge clk25); #1;
            checkOutput("rst_out", int'(audioOut), 0);
            checkOutput("rst_sd", int'(audioSD), 0);
            checkOutput("rst_busy", int'(busy), 0);
        end
        @(negedge clk25);
        reset = 1'b1;
        @(posedge clk25); #1;
        checkOutput("first_busy", int'(busy), 1);
        checkOutput("first_sd", int'(audioSD), 1);
        checkOutput("first_out", int'(audioOut), 1);

        // Table-driven segments.
        doReset();
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].en, vecs[i].pitch, vecs[i].vol);
            highs = 0;
            for (int c = 0; c < vecs[i].cycles; c++) begin
                @(posedge clk25); #1;
                highs += int'(audioOut);
            end
            checkOutput($sformatf("vec%0d_highs", i), highs, vecs[i].expHighs);
            checkOutput($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].expBusy));
            checkOutput($sformatf("vec%0d_sd", i), int'(audioSD), int'(vecs[i].expBusy));
        end

        // Gate drops 5 cycles into a 20-cycle high half: the note finishes
        // its period and all outputs fall together at edge 41.
        doReset();
        applyStimulus(1'b1, 20, 15);
        for (int e = 1; e <= 5; e++) begin
            @(posedge clk25); #1;
        end
        applyStimulus(1'b0, 20, 15);
        busyCount = 0; fallEdge = -1; outAtFall = 1; sdAtFall = 1; highCount = 0;
        for (int e = 6; e <= 100 && fallEdge < 0; e++) begin
            @(posedge clk25); #1;
            if (busy) busyCount++;
            else begin
                fallEdge  = e;
                outAtFall = int'(audioOut);
                sdAtFall  = int'(audioSD);
            end
            if (e <= 20) highCount += int'(audioOut);
        end
        checkOutput("drain_fall_edge", fallEdge, 41);
        checkOutput("drain_busy_cycles", busyCount, 35);
        checkOutput("drain_high_tail", highCount, 14);
        checkOutput("drain_out_at_fall", outAtFall, 0);
        checkOutput("drain_sd_at_fall", sdAtFall, 0);

        // Gate comes back during the low half: no phase jump.
        doReset();
        applyStimulus(1'b1, 20, 15);
        for (int e = 1; e <= 5; e++) begin
            @(posedge clk25); #1;
        end
        applyStimulus(1'b0, 20, 15);
        for (int e = 6; e <= 25; e++) begin
            @(posedge clk25); #1;
        end
        applyStimulus(1'b1, 20, 15);
        for (int e = 26; e <= 61; e++) begin
            @(posedge clk25); #1;
            if (e == 40) checkOutput("retrig_e40_out", int'(audioOut), 0);
            if (e == 41) checkOutput("retrig_e41_out", int'(audioOut), 1);
            if (e == 41) checkOutput("retrig_e41_busy", int'(busy), 1);
            if (e == 60) checkOutput("retrig_e60_busy", int'(busy), 1);
            if (e == 61) checkOutput("retrig_e61_out", int'(audioOut), 0);
        end

        // Pitch 20 -> 30 mid-half: current half stays 20, next is 30.
        doReset();
        applyStimulus(1'b1, 20, 15);
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk25); #1;
        end
        applyStimulus(1'b1, 30, 15);
        for (int e = 8; e <= 51; e++) begin
            @(posedge clk25); #1;
            if (e == 20) checkOutput("pchg_e20_out", int'(audioOut), 1);
            if (e == 21) checkOutput("pchg_e21_out", int'(audioOut), 0);
            if (e == 50) checkOutput("pchg_e50_out", int'(audioOut), 0);
            if (e == 51) checkOutput("pchg_e51_out", int'(audioOut), 1);
        end

        // Asynchronous reset mid-note clears outputs before the next edge.
        doReset();
        applyStimulus(1'b1, 20, 15);
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk25); #1;
        end
        checkOutput("areset_pre_out", int'(audioOut), 1);
        #5;
        reset = 1'b0;
        #1;
        checkOutput("areset_out", int'(audioOut), 0);
        checkOutput("areset_sd", int'(audioSD), 0);
        checkOutput("areset_busy", int'(busy), 0);
        @(negedge clk25);
        audioEn = 1'b0;
        reset = 1'b1;
        @(posedge clk25); #1;
        checkOutput("areset_idle_busy", int'(busy), 0);

        // Randomized run against the reference model.
        doReset();
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk25);
            if ($urandom_range(0, 59) == 0) audioEn = ~audioEn;
            if ($urandom_range(0, 39) == 0) pitch = randPitch();
            if ($urandom_range(0, 29) == 0) volume = VOL_W'($urandom_range(0, 15));
            reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            if (!reset) begin
                modelReset();
                #1;
                compareModel("rand_async");
            end
            @(posedge clk25);
            if (reset) modelStep(audioEn, int'(pitch), int'(volume));
            else modelReset();
            #1;
            compareModel("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
